// File: rtl/tri_bus_reader.sv
// tri_bus_reader: captures words from a shared tri-state bus into a small FIFO.
// The bus is sampled only while the remote driver enables it. A single
// turnaround cycle is required after each burst, and enabling the bus during
// that cycle is flagged as an error.
// The optional even-parity check is built only when PARITY_CHECK_EN is defined.
module tri_bus_reader #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bus_en,
  input  logic [DW-1:0]          bus_data,
  input  logic                   bus_par,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   bus_hold,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_ovf,
  output logic                   err_turn,
  output logic                   err_par,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_TURN    = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          capture, turn_viol, push, pop, drop;

  // The bus is only ours to sample outside the turnaround cycle. A pop frees
  // a slot in the same cycle, so a full FIFO can still accept a word when the
  // consumer is reading.
  always_comb begin
    capture   = bus_en && (state == S_IDLE || state == S_CAPTURE);
    turn_viol = bus_en && (state == S_TURN);
    pop       = (count != '0) && out_ready;
    push      = capture && ((count != CW'(DEPTH)) || pop);
    drop      = capture && !push;
  end

  // Next-state selection; an enable during TURN extends TURN by one more cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = bus_en ? S_CAPTURE : S_IDLE;
      S_CAPTURE: state_nxt = bus_en ? S_CAPTURE : S_TURN;
      S_TURN:    state_nxt = bus_en ? S_TURN    : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FIFO storage and pointers. Entries are cleared on reset so the head reads
  // zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= bus_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign out_data  = mem[rptr];
  assign out_valid = (count != '0);
  assign bus_hold  = (count == CW'(DEPTH));

  // Sticky overflow and turnaround flags; a clear wins over a new set.
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      err_ovf  <= 1'b0;
      err_turn <= 1'b0;
    end else begin
      if (drop)      err_ovf  <= 1'b1;
      if (turn_viol) err_turn <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_bad;
  assign par_bad = capture && (bus_par != ^bus_data);

  // Sticky parity flag; a mismatching word is still pushed.
  always_ff @(posedge clk) begin
    if (reset || err_clr) err_par <= 1'b0;
    else if (par_bad)     err_par <= 1'b1;
  end
`else
  logic unused_par;
  assign unused_par = bus_par;
  assign err_par    = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_reader.sv
// Bench for tri_bus_reader: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_tri_bus_reader;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 0;
  logic          reset, bus_en, bus_par, out_ready, err_clr;
  logic [DW-1:0] bus_data, out_data;
  logic          out_valid, bus_hold, err_ovf, err_turn, err_par;
  logic [$clog2(DEPTH):0] count;

  tri_bus_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus_en(bus_en), .bus_data(bus_data),
    .bus_par(bus_par), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .bus_hold(bus_hold), .count(count),
    .err_ovf(err_ovf), .err_turn(err_turn), .err_par(err_par),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus "are we mid-burst" and
  // "are we in the turnaround gap" bits.
  logic [DW-1:0] q[$];
  bit m_burst, m_gap, m_live, m_fresh;
  bit m_ovf, m_turn, m_par;

  always @(posedge clk) begin
    bit can_take, do_pop, do_push;
    if (reset) begin
      q.delete();
      m_burst = 0; m_gap = 0; m_live = 1; m_fresh = 1;
      m_ovf = 0; m_turn = 0; m_par = 0;
    end else if (m_live) begin
      can_take = bus_en && !m_gap;
      do_pop   = (q.size() > 0) && out_ready;
      do_push  = can_take && (q.size() < DEPTH || do_pop);
      if (err_clr) begin
        m_ovf = 0; m_turn = 0; m_par = 0;
      end else begin
        if (can_take && !do_push) m_ovf = 1;
        if (bus_en && m_gap) m_turn = 1;
`ifdef PARITY_CHECK_EN
        if (can_take && (bus_par != ^bus_data)) m_par = 1;
`endif
      end
      if (m_gap) m_gap = bus_en;
      else if (bus_en) m_burst = 1;
      else if (m_burst) begin m_burst = 0; m_gap = 1; end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin q.push_back(bus_data); m_fresh = 0; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("bus_hold", 32'(bus_hold), 32'(q.size() == DEPTH));
      if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
      else if (m_fresh)  chk("out_data_rst", 32'(out_data), 32'h0);
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_turn", 32'(err_turn), 32'(m_turn));
      chk("err_par", 32'(err_par), 32'(m_par));
    end
  end

  task automatic cyc(input bit en, input logic [DW-1:0] d, input bit rdy,
                     input bit clr = 0, input bit rst = 0, input bit par = 0);
    bus_en = en; bus_data = d; out_ready = rdy; err_clr = clr; reset = rst; bus_par = par;
    @(posedge clk); #1;
  endtask

  initial begin
    bus_en = 0; bus_data = '0; bus_par = 0; out_ready = 0; err_clr = 0; reset = 1;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_hold", 32'(bus_hold), 0);
    chk("rst_flags", {29'd0, err_ovf, err_turn, err_par}, 0);

    // Three-word burst, consumer stalled.
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    chk("burst_count", 32'(count), 3);
    chk("burst_head", 32'(out_data), 32'h11);
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // Overflow: fifth word dropped.
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 4) chk("ovf_hold4", 32'(bus_hold), 1);
    end
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(err_ovf), 1);
    chk("ovf_head", 32'(out_data), 32'h01);
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", 32'(err_ovf), 0);

    // Full FIFO: simultaneous push and pop.
    cyc(1, 8'hAA, 1);
    chk("full_pp_count", 32'(count), 4);
    chk("full_pp_head", 32'(out_data), 32'h02);
    chk("full_pp_ovf", 32'(err_ovf), 0);
    begin
      logic [DW-1:0] exp_d [4];
      exp_d[0] = 8'h03; exp_d[1] = 8'h04; exp_d[2] = 8'hAA; exp_d[3] = 8'h00;
      for (int i = 0; i < 3; i++) begin
        cyc(0, 0, 1);
        chk("drain_head", 32'(out_data), 32'(exp_d[i]));
      end
    end
    cyc(0, 0, 1);
    chk("drain_empty", 32'(out_valid), 0);
    cyc(0, 0, 0);

    // Turnaround violation.
    cyc(1, 8'h5A, 0); cyc(0, 8'h00, 0); cyc(1, 8'h6B, 0);
    chk("turn_count", 32'(count), 1);
    chk("turn_head", 32'(out_data), 32'h5A);
    chk("turn_flag", 32'(err_turn), 1);
    cyc(0, 0, 0); cyc(0, 0, 0, 1);
    chk("turn_clr", 32'(err_turn), 0);
    cyc(0, 0, 1); cyc(0, 0, 0);

    // Reset mid-burst.
    cyc(1, 8'h41, 0); cyc(1, 8'h42, 0);
    cyc(1, 8'h43, 0, 0, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    cyc(1, 8'h77, 0);
    chk("resume_head", 32'(out_data), 32'h77);
    cyc(0, 0, 1); cyc(0, 0, 0);

    // Parity: 0x03 has even parity 0, so bus_par=1 is a mismatch.
    cyc(1, 8'h03, 0, 0, 0, 1);
    chk("par_head", 32'(out_data), 32'h03);
`ifdef PARITY_CHECK_EN
    chk("par_flag", 32'(err_par), 1);
`else
    chk("par_flag", 32'(err_par), 0);
`endif
    cyc(0, 0, 1); cyc(0, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [DW-1:0] d;
      bit en, rdy, clr, rst, par;
      d   = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 250) == 0);
      par = ($urandom_range(0, 15) == 0) ? ~(^d) : (^d);
      cyc(en, d, rdy, clr, rst, par);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tri_bus_reader.md
TRI_BUS_READER -- requirements
Module: tri_bus_reader

Interface
REQ-001 Parameter DW, default 8, is the width of the data word on the shared bus.
REQ-002 Parameter DEPTH, default 4, is the number of capture FIFO entries (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port bus_en, input, 1 bit: the remote driver's tri-state enable; the bus carries a valid word when it is high.
REQ-006 Port bus_data, input, DW bits: the resolved value of the shared tri-state bus.
REQ-007 Port bus_par, input, 1 bit: the even-parity bit over bus_data (used only when PARITY_CHECK_EN is defined).
REQ-008 Port out_data, output, DW bits: the word at the FIFO head.
REQ-009 Port out_valid, output, 1 bit: out_data is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-011 Port bus_hold, output, 1 bit: backpressure to the driver side; high when the FIFO is full.
REQ-012 Port count, output, log2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-013 Port err_ovf, output, 1 bit: sticky flag for a word dropped because the FIFO was full.
REQ-014 Port err_turn, output, 1 bit: sticky flag for a turnaround violation.
REQ-015 Port err_par, output, 1 bit: sticky parity error flag; tied 0 when parity checking is compiled out.
REQ-016 Port err_clr, input, 1 bit: clears all sticky error flags.

Function
REQ-017 The FSM SHALL have three states:
- IDLE
- CAPTURE
- TURN
REQ-018 IDLE: bus_en=1 SHALL move to CAPTURE and capture bus_data in the same cycle.
REQ-019 CAPTURE: bus_en=1 SHALL capture one word per cycle; bus_en=0 SHALL move to TURN.
REQ-020 TURN SHALL last exactly one cycle, then return to IDLE.
REQ-021 bus_en=1 during TURN SHALL drop the word, set err_turn, and stay in TURN for one more cycle.
REQ-022 A capture SHALL be a push, accepted when count<DEPTH or when a pop occurs in the same cycle.
REQ-023 When the FIFO is full and no pop occurs, the word SHALL be dropped and err_ovf set.
REQ-024 A pop SHALL occur when out_valid and out_ready are both high.
REQ-025 out_valid SHALL equal (count!=0).
REQ-026 out_data SHALL be driven directly from the head entry, so a word is visible on the cycle after its push (latency 1 cycle).
REQ-027 Push and pop in the same cycle SHALL leave count unchanged, both when count=DEPTH and when count is between 1 and DEPTH-1.
REQ-028 A push on an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH, with no gap or duplicated word at the wrap.
REQ-030 bus_hold SHALL equal (count==DEPTH).
REQ-031 Each sticky flag SHALL stay set until err_clr=1; on the clearing cycle err_clr SHALL take priority over a new set.

Reset
REQ-032 reset=1 SHALL force, on the next rising edge:
- state to IDLE
- count=0 and both pointers to 0
- out_valid=0 and bus_hold=0
- err_ovf, err_turn and err_par to 0
REQ-033 out_data SHALL read 0 after reset until the first push.
REQ-034 reset SHALL override every push, pop and error set in the same cycle.
REQ-035 reset asserted mid-CAPTURE SHALL discard all FIFO contents, and capture SHALL resume only on a bus_en high seen in IDLE.

Configuration
REQ-036 When PARITY_CHECK_EN is defined, each captured word SHALL be checked against bus_par.
REQ-037 With PARITY_CHECK_EN defined, a mismatch SHALL set err_par; the word SHALL still be pushed.
REQ-038 When PARITY_CHECK_EN is not defined, bus_par SHALL be ignored, err_par SHALL be a constant 0, and no parity logic SHALL be built.

Verification
REQ-039 Burst test: bus_en high for 3 cycles with data 0x11, 0x22, 0x33 and out_ready=0 -> count=3, head=0x11; after TURN, state is IDLE.
REQ-040 Overflow test: 5-word burst 0x01..0x05, DEPTH=4, out_ready=0 -> bus_hold=1 after the 4th word, 0x05 dropped, err_ovf=1, FIFO holds 0x01..0x04.
REQ-041 Full push/pop test: with the FIFO full, push 0xAA while out_ready=1 -> 0x01 popped, 0xAA accepted, count stays 4, err_ovf stays 0.
REQ-042 Turnaround test: bus_en pattern 1,0,1 with data 0x5A, x, 0x6B -> only 0x5A captured, err_turn=1; err_clr pulse -> err_turn=0.
REQ-043 Reset test: reset pulse mid-burst after 2 words -> next edge count=0, out_valid=0, all flags 0; a new burst 0x77 yields head 0x77.
REQ-044 Parity test (with PARITY_CHECK_EN): data 0x03 with bus_par=1 -> err_par=1 and 0x03 stored; without the macro, the same stimulus -> err_par=0.
